// File: rtl/piso_pkg.sv
// Shared types and helpers for the handshaked PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // The bit that leaves first is the MSB or the LSB, depending on the chosen bit order.
  function automatic logic bit_sel(input logic msb, input logic lsb, input logic lsb_first);
    return lsb_first ? lsb : msb;
  endfunction

endpackage

// File: rtl/piso_serializer_hs_hold.sv
// One-entry valid/ready holding buffer that decouples the producer from the shifter.
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid
);

  logic [WIDTH-1:0] hold_reg;

  assign s_ready   = !hold_valid && !rst;
  assign hold_data = hold_reg;

  // An accept needs an empty buffer and a pop needs a full one, so the two never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_reg   <= '0;
    end else if (s_valid && s_ready) begin
      hold_reg   <= s_data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out shifter with input handshake, gap-free word chaining and framing flags.
module piso_serializer_hs
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  piso_state_t      state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             end_of_word;
  logic             load;

  assign end_of_word = (state == SHIFT) && ser_en && (bit_cnt == LAST_CNT);
  assign load        = hold_valid && ((state == IDLE) || end_of_word);

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .pop        (load),
    .hold_data  (hold_data),
    .hold_valid (hold_valid)
  );

  // Loading on the last bit edge chains the next word with no idle bit in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= hold_data;
      bit_cnt   <= '0;
      state     <= SHIFT;
    end else if (end_of_word) begin
      state <= IDLE;
    end else if ((state == SHIFT) && ser_en) begin
      shift_reg <= LSB_FIRST ? {1'b0, shift_reg[WIDTH-1:1]} : {shift_reg[WIDTH-2:0], 1'b0};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid ? bit_sel(shift_reg[WIDTH-1], shift_reg[0], LSB_FIRST) : IDLE_LEVEL;
  assign ser_first = ser_valid && (bit_cnt == '0);
  assign ser_last  = ser_valid && (bit_cnt == LAST_CNT);
  assign busy      = ser_valid || hold_valid;

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Self-checking bench: three serializer configurations share one stimulus bus, one is observed at a time.
module tb_piso_serializer_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       ser_en = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic [2:0] ready_v, out_v, valid_v, first_v, last_v, busy_v;
  logic       o_ready, o_out, o_valid, o_first, o_last, o_busy;
  int         sel = 0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of waiting words plus the active word and bit position.
  logic [7:0] m_pending[$];
  bit         m_active;
  logic [7:0] m_word;
  int         m_idx;
  int         m_w;
  bit         m_lsb;
  logic       m_idle;

  always #5 clk = ~clk;

  piso_serializer_hs #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready_v[0]), .s_data(s_data),
    .ser_en(ser_en), .ser_out(out_v[0]), .ser_valid(valid_v[0]), .ser_first(first_v[0]),
    .ser_last(last_v[0]), .busy(busy_v[0]));

  piso_serializer_hs #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready_v[1]), .s_data(s_data),
    .ser_en(ser_en), .ser_out(out_v[1]), .ser_valid(valid_v[1]), .ser_first(first_v[1]),
    .ser_last(last_v[1]), .busy(busy_v[1]));

  piso_serializer_hs #(.WIDTH(2), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready_v[2]), .s_data(s_data[1:0]),
    .ser_en(ser_en), .ser_out(out_v[2]), .ser_valid(valid_v[2]), .ser_first(first_v[2]),
    .ser_last(last_v[2]), .busy(busy_v[2]));

  always_comb begin
    o_ready = ready_v[sel];
    o_out   = out_v[sel];
    o_valid = valid_v[sel];
    o_first = first_v[sel];
    o_last  = last_v[sel];
    o_busy  = busy_v[sel];
  end

  function automatic logic exp_out();
    if (!m_active) return m_idle;
    return m_lsb ? m_word[m_idx] : m_word[m_w-1-m_idx];
  endfunction

  task automatic set_sel(input int s);
    sel    = s;
    m_w    = (s == 2) ? 2 : 8;
    m_lsb  = (s == 1);
    m_idle = (s == 1);
  endtask

  task automatic model_clear();
    m_pending.delete();
    m_active = 0;
    m_idx    = 0;
    m_word   = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; ser_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one cycle of stimulus and advance the model across the rising edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic e, output bit acc);
    bit load;
    logic [7:0] mask;
    mask = (m_w == 8) ? 8'hFF : 8'h03;
    s_valid = v; s_data = d; ser_en = e;
    acc  = v && (m_pending.size() == 0);
    load = (m_pending.size() != 0) && (!m_active || (e && m_idx == m_w - 1));
    @(posedge clk);
    if (m_active && e) begin
      if (m_idx == m_w - 1) m_active = 0;
      else m_idx++;
    end
    if (load) begin
      m_active = 1;
      m_idx    = 0;
      m_word   = m_pending.pop_front();
    end
    if (acc) m_pending.push_back(d & mask);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_sel(0);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; ser_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got=%b want=0", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b want=0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out got=%b want=0", o_out); end
    n_cmp++; if ({o_first, o_last} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags got=%b want=00", {o_first, o_last}); end
    rst = 1'b0; s_valid = 1'b0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready got=%b want=1", o_ready); end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy got=%b want=0", o_busy); end
    model_clear();
  endtask

  task automatic test_single_word(input int s, input logic [7:0] exp_seq, input logic idle_lvl);
    logic [7:0] seq;
    int nbits;
    bit acc;
    set_sel(s);
    do_reset();
    seq = 8'h00; nbits = 0;
    tick(1'b1, 8'hC1, 1'b1, acc);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 8'h00, 1'b1, acc);
      if (o_valid) begin
        seq = {seq[6:0], o_out};
        nbits++;
        n_cmp++; if (o_first !== (nbits == 1)) begin n_fail++; $display("[TB] FAIL single_first sel=%0d bit=%0d got=%b", s, nbits, o_first); end
        n_cmp++; if (o_last !== (nbits == 8)) begin n_fail++; $display("[TB] FAIL single_last sel=%0d bit=%0d got=%b", s, nbits, o_last); end
      end
    end
    n_cmp++; if (nbits != 8) begin n_fail++; $display("[TB] FAIL single_count sel=%0d got=%0d want=8", s, nbits); end
    n_cmp++; if (seq !== exp_seq) begin n_fail++; $display("[TB] FAIL single_seq sel=%0d got=%h want=%h", s, seq, exp_seq); end
    n_cmp++; if (o_out !== idle_lvl || o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle sel=%0d out=%b valid=%b want out=%b valid=0", s, o_out, o_valid, idle_lvl); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[2];
    logic [15:0] seq;
    int wi, run, maxrun;
    bit acc, prev_last;
    set_sel(0);
    do_reset();
    words[0] = 8'hA5; words[1] = 8'h3C;
    wi = 0; run = 0; maxrun = 0; seq = 16'h0; prev_last = 0;
    for (int c = 0; c < 24; c++) begin
      tick(wi < 2, (wi < 2) ? words[wi] : 8'h00, 1'b1, acc);
      if (acc) wi++;
      n_cmp++; if (o_ready !== (m_pending.size() == 0)) begin n_fail++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b want=%b", c, o_ready, m_pending.size() == 0); end
      if (o_valid) begin
        run++;
        seq = {seq[14:0], o_out};
        if (prev_last) begin
          n_cmp++; if (o_first !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_join cyc=%0d first=%b want=1", c, o_first); end
        end
      end else run = 0;
      if (run > maxrun) maxrun = run;
      prev_last = o_valid && o_last;
    end
    n_cmp++; if (maxrun != 16) begin n_fail++; $display("[TB] FAIL b2b_run got=%0d want=16", maxrun); end
    n_cmp++; if (seq !== 16'hA53C) begin n_fail++; $display("[TB] FAIL b2b_seq got=%h want=a53c", seq); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words[3];
    logic [23:0] stream;
    int wi, nbits;
    bit acc;
    logic e;
    set_sel(0);
    do_reset();
    for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
    wi = 0; nbits = 0; stream = '0;
    for (int c = 0; c < 64; c++) begin
      e = (c % 2 == 0);
      if (o_valid && e) begin
        stream = {stream[22:0], o_out};
        nbits++;
      end
      tick(wi < 3, (wi < 3) ? words[wi] : 8'h00, e, acc);
      if (acc) wi++;
      n_cmp++; if (o_ready !== (m_pending.size() == 0)) begin n_fail++; $display("[TB] FAIL bp_ready cyc=%0d got=%b want=%b", c, o_ready, m_pending.size() == 0); end
      n_cmp++; if (o_valid !== m_active || o_out !== exp_out()) begin n_fail++; $display("[TB] FAIL bp_bit cyc=%0d valid=%b out=%b want valid=%b out=%b", c, o_valid, o_out, m_active, exp_out()); end
    end
    n_cmp++; if (nbits != 24) begin n_fail++; $display("[TB] FAIL bp_count got=%0d want=24", nbits); end
    n_cmp++; if (stream !== {words[0], words[1], words[2]}) begin n_fail++; $display("[TB] FAIL bp_stream got=%h want=%h", stream, {words[0], words[1], words[2]}); end
  endtask

  task automatic test_reset_mid_frame();
    bit acc, reached;
    int wi;
    set_sel(0);
    do_reset();
    wi = 0; reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      tick(wi < 2, (wi == 0) ? 8'hFF : 8'h5A, 1'b1, acc);
      if (acc) wi++;
      reached = m_active && (m_idx == 3) && (m_pending.size() == 1);
    end
    n_cmp++; if (!reached || o_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_setup reached=%b busy=%b want 1/1", reached, o_busy); end
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid got=%b want=0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got=%b want=0", o_busy); end
    n_cmp++; if (o_out !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out got=%b want=0", o_out); end
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 8'h00, 1'b1, acc);
      n_cmp++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_resume cyc=%0d valid=%b busy=%b want 0/0", c, o_valid, o_busy); end
    end
  endtask

  task automatic test_width2();
    logic [3:0] seq, fseq, lseq;
    int wi, nbits;
    bit acc;
    logic [7:0] words[2];
    set_sel(2);
    do_reset();
    words[0] = 8'h02; words[1] = 8'h01;
    wi = 0; nbits = 0; seq = '0; fseq = '0; lseq = '0;
    for (int c = 0; c < 8; c++) begin
      tick(wi < 2, (wi < 2) ? words[wi] : 8'h00, 1'b1, acc);
      if (acc) wi++;
      if (o_valid) begin
        seq  = {seq[2:0], o_out};
        fseq = {fseq[2:0], o_first};
        lseq = {lseq[2:0], o_last};
        nbits++;
      end
    end
    n_cmp++; if (nbits != 4) begin n_fail++; $display("[TB] FAIL w2_count got=%0d want=4", nbits); end
    n_cmp++; if (seq !== 4'b1001) begin n_fail++; $display("[TB] FAIL w2_seq got=%b want=1001", seq); end
    n_cmp++; if (fseq !== 4'b1010) begin n_fail++; $display("[TB] FAIL w2_first got=%b want=1010", fseq); end
    n_cmp++; if (lseq !== 4'b0101) begin n_fail++; $display("[TB] FAIL w2_last got=%b want=0101", lseq); end
  endtask

  task automatic test_random();
    bit acc;
    for (int s = 0; s < 3; s++) begin
      set_sel(s);
      do_reset();
      for (int c = 0; c < 300; c++) begin
        tick(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0, acc);
        n_cmp++; if (o_valid !== m_active) begin n_fail++; $display("[TB] FAIL rnd_valid sel=%0d cyc=%0d got=%b want=%b", s, c, o_valid, m_active); end
        n_cmp++; if (o_out !== exp_out()) begin n_fail++; $display("[TB] FAIL rnd_out sel=%0d cyc=%0d got=%b want=%b", s, c, o_out, exp_out()); end
        n_cmp++; if (o_first !== (m_active && m_idx == 0)) begin n_fail++; $display("[TB] FAIL rnd_first sel=%0d cyc=%0d got=%b", s, c, o_first); end
        n_cmp++; if (o_last !== (m_active && m_idx == m_w - 1)) begin n_fail++; $display("[TB] FAIL rnd_last sel=%0d cyc=%0d got=%b", s, c, o_last); end
        n_cmp++; if (o_busy !== (m_active || m_pending.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_busy sel=%0d cyc=%0d got=%b", s, c, o_busy); end
        n_cmp++; if (o_ready !== (m_pending.size() == 0)) begin n_fail++; $display("[TB] FAIL rnd_ready sel=%0d cyc=%0d got=%b", s, c, o_ready); end
      end
    end
  endtask

  initial begin
    set_sel(0);
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_word(0, 8'hC1, 1'b0);
    test_single_word(1, 8'h83, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_width2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
